// File: rtl/pipeline_hazard_scheduler.sv
// Issue scheduler for the 3-stage pipeline. It keeps a pending-write counter
// per register, limits the number of instructions in flight and serialises
// control transfers. It drives STALL, ISSUE_ACCEPT and a one-cycle FLUSH.
//
// Issue handshake: ISSUE_VALID is the valid and ISSUE_ACCEPT is the
// transfer. An instruction moves out of decode only in a cycle where both
// are high. STALL is the inverse of ready, qualified by ISSUE_VALID.
// Decode must hold its instruction stable while STALL is high.
module pipeline_hazard_scheduler #(
    parameter int REGNOBITS   = 5,
    parameter int NUMREGS     = 32,
    parameter int CNTBITS     = 2,
    parameter int MAXINFLIGHT = 2,
    parameter int FLIGHTBITS  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ISSUE_VALID,
    input  logic                  ISSUE_WB,
    input  logic [REGNOBITS-1:0]  ISSUE_RD,
    input  logic                  ISSUE_CTRL,
    input  logic [REGNOBITS-1:0]  SRC1_REG,
    input  logic                  SRC1_USED,
    input  logic [REGNOBITS-1:0]  SRC2_REG,
    input  logic                  SRC2_USED,
    input  logic                  RETIRE_VALID,
    input  logic                  RETIRE_WB,
    input  logic [REGNOBITS-1:0]  RETIRE_RD,
    input  logic                  RESOLVE,
    input  logic                  RESOLVE_TAKEN,
    output logic                  STALL,
    output logic                  ISSUE_ACCEPT,
    output logic                  FLUSH,
    output logic [NUMREGS-1:0]    BUSY_VEC,
    output logic [FLIGHTBITS-1:0] INFLIGHT,
    output logic                  ERR,
    output logic [1:0]            CTRL_STATE
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RES = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNTBITS-1:0] cnt [NUMREGS];

    logic raw_hazard;
    logic waw_overflow;
    logic full;
    logic retire_ok;
    logic retire_wb;
    logic err_zero_dec;
    logic err_retire;
    logic err_resolve;

    // Hazard terms look only at the registered counters. A retire in the
    // same cycle writes the register file at the same edge, so the reader
    // still has to wait one cycle.
    always_comb begin
        raw_hazard   = (SRC1_USED && (cnt[SRC1_REG] != '0)) ||
                       (SRC2_USED && (cnt[SRC2_REG] != '0));
        waw_overflow = ISSUE_WB && (cnt[ISSUE_RD] == '1);
        full         = (INFLIGHT == FLIGHTBITS'(MAXINFLIGHT));
        retire_ok    = RETIRE_VALID && (INFLIGHT != '0);
        retire_wb    = retire_ok && RETIRE_WB;
        err_zero_dec = retire_wb && (cnt[RETIRE_RD] == '0);
        err_retire   = RETIRE_VALID && (INFLIGHT == '0);
        err_resolve  = RESOLVE && (state != S_WAIT_RES);
    end

    // Control FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_next;
    end

    // Control FSM next state: one unresolved control transfer at a time.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (ISSUE_ACCEPT && ISSUE_CTRL) state_next = S_WAIT_RES;
            S_WAIT_RES: if (RESOLVE) state_next = RESOLVE_TAKEN ? S_FLUSH : S_IDLE;
            S_FLUSH:    state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Control FSM outputs and issue gating. Reset forces a safe stall.
    always_comb begin
        STALL        = RESET || (ISSUE_VALID &&
                       (raw_hazard || waw_overflow || full || (state != S_IDLE)));
        ISSUE_ACCEPT = ISSUE_VALID && !STALL;
        FLUSH        = (state == S_FLUSH) && !RESET;
        CTRL_STATE   = state;
    end

    // Per-register pending-write counters; issue and retire together cancel.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int r = 0; r < NUMREGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUMREGS; r++) begin
                logic inc;
                logic dec_ok;
                inc    = ISSUE_ACCEPT && ISSUE_WB && (ISSUE_RD == REGNOBITS'(r));
                dec_ok = retire_wb && (RETIRE_RD == REGNOBITS'(r)) && (cnt[r] != '0);
                if (inc && !dec_ok)      cnt[r] <= cnt[r] + 1'b1;
                else if (dec_ok && !inc) cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // In-flight count: accepted but not yet retired instructions.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            INFLIGHT <= '0;
        end else begin
            case ({ISSUE_ACCEPT, retire_ok})
                2'b10:   INFLIGHT <= INFLIGHT + 1'b1;
                2'b01:   INFLIGHT <= INFLIGHT - 1'b1;
                default: INFLIGHT <= INFLIGHT;
            endcase
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge CLK) begin
        if (RESET) ERR <= 1'b0;
        else       ERR <= ERR || err_zero_dec || err_retire || err_resolve;
    end

    // Busy view of the counters, forced clear while in reset.
    always_comb begin
        for (int i = 0; i < NUMREGS; i++) BUSY_VEC[i] = !RESET && (cnt[i] != '0);
    end

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Directed bench for pipeline_hazard_scheduler: a table of one-cycle vectors
// followed by hand-written multi-cycle sequences for branches and reset.
module tb_pipeline_hazard_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ISSUE_VALID, ISSUE_WB, ISSUE_CTRL;
    logic [4:0]  ISSUE_RD, SRC1_REG, SRC2_REG, RETIRE_RD;
    logic        SRC1_USED, SRC2_USED;
    logic        RETIRE_VALID, RETIRE_WB, RESOLVE, RESOLVE_TAKEN;
    logic        STALL, ISSUE_ACCEPT, FLUSH, ERR;
    logic [31:0] BUSY_VEC;
    logic [1:0]  INFLIGHT, CTRL_STATE;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [31:0] B = 32'd1;

    // clock / reset
    always #5 CLK = ~CLK;

    pipeline_hazard_scheduler dut (
        .CLK(CLK), .RESET(RESET),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_WB(ISSUE_WB), .ISSUE_RD(ISSUE_RD),
        .ISSUE_CTRL(ISSUE_CTRL),
        .SRC1_REG(SRC1_REG), .SRC1_USED(SRC1_USED),
        .SRC2_REG(SRC2_REG), .SRC2_USED(SRC2_USED),
        .RETIRE_VALID(RETIRE_VALID), .RETIRE_WB(RETIRE_WB), .RETIRE_RD(RETIRE_RD),
        .RESOLVE(RESOLVE), .RESOLVE_TAKEN(RESOLVE_TAKEN),
        .STALL(STALL), .ISSUE_ACCEPT(ISSUE_ACCEPT), .FLUSH(FLUSH),
        .BUSY_VEC(BUSY_VEC), .INFLIGHT(INFLIGHT), .ERR(ERR),
        .CTRL_STATE(CTRL_STATE)
    );

    typedef struct {
        string       name;
        logic        iv, iwb;
        logic [4:0]  ird;
        logic        ictrl;
        logic [4:0]  s1;
        logic        s1u;
        logic [4:0]  s2;
        logic        s2u;
        logic        rv, rwb;
        logic [4:0]  rrd;
        logic        res, tak, rst;
        logic        e_stall, e_acc, e_flush;
        logic [31:0] e_busy;
        logic [1:0]  e_infl;
        logic        e_err;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(string n, logic iv, logic iwb, logic [4:0] ird, logic ictrl,
                               logic [4:0] s1, logic s1u, logic [4:0] s2, logic s2u,
                               logic rv, logic rwb, logic [4:0] rrd,
                               logic res, logic tak, logic rst,
                               logic es, logic ea, logic ef, logic [31:0] eb,
                               logic [1:0] ei, logic ee, logic [1:0] est);
        vec_t t;
        t.name = n; t.iv = iv; t.iwb = iwb; t.ird = ird; t.ictrl = ictrl;
        t.s1 = s1; t.s1u = s1u; t.s2 = s2; t.s2u = s2u;
        t.rv = rv; t.rwb = rwb; t.rrd = rrd; t.res = res; t.tak = tak; t.rst = rst;
        t.e_stall = es; t.e_acc = ea; t.e_flush = ef; t.e_busy = eb;
        t.e_infl = ei; t.e_err = ee; t.e_state = est;
        return t;
    endfunction

    // driver tasks
    task automatic clr_in();
        ISSUE_VALID = 0; ISSUE_WB = 0; ISSUE_RD = 0; ISSUE_CTRL = 0;
        SRC1_REG = 0; SRC1_USED = 0; SRC2_REG = 0; SRC2_USED = 0;
        RETIRE_VALID = 0; RETIRE_WB = 0; RETIRE_RD = 0;
        RESOLVE = 0; RESOLVE_TAKEN = 0;
    endtask

    task automatic drive(input vec_t t);
        ISSUE_VALID = t.iv; ISSUE_WB = t.iwb; ISSUE_RD = t.ird; ISSUE_CTRL = t.ictrl;
        SRC1_REG = t.s1; SRC1_USED = t.s1u; SRC2_REG = t.s2; SRC2_USED = t.s2u;
        RETIRE_VALID = t.rv; RETIRE_WB = t.rwb; RETIRE_RD = t.rrd;
        RESOLVE = t.res; RESOLVE_TAKEN = t.tak; RESET = t.rst;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // scoreboard compare
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        //            name            iv iwb ird ct s1 u1 s2 u2 rv rwb rrd rs tk rst | st ac fl busy              inf er st
        tbl.push_back(v("rst",          1, 1, 3, 0, 0, 0, 0, 0, 1, 1, 3, 1, 1, 1,  1, 0, 0, 0,                0, 0, 0));
        tbl.push_back(v("addi_r3",      1, 1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("raw_stall",    1, 1, 4, 0, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, B<<3,             1, 0, 0));
        tbl.push_back(v("raw_same_ret", 1, 1, 4, 0, 3, 1, 5, 1, 1, 1, 3, 0, 0, 0,  1, 0, 0, B<<3,             1, 0, 0));
        tbl.push_back(v("raw_accept",   1, 1, 4, 0, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("ret_r4",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0,  0, 0, 0, B<<4,             1, 0, 0));
        tbl.push_back(v("acc_r7",       1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("r7_iss_ret",   1, 1, 7, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0,  0, 1, 0, B<<7,             1, 0, 0));
        tbl.push_back(v("r7_hold",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, B<<7,             1, 0, 0));
        tbl.push_back(v("ret_r7",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0,  0, 0, 0, B<<7,             1, 0, 0));
        tbl.push_back(v("cap_a",        1, 1,10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("cap_b",        1, 1,11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, B<<10,            1, 0, 0));
        tbl.push_back(v("cap_c_stall",  1, 1,12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, (B<<10)|(B<<11),  2, 0, 0));
        tbl.push_back(v("cap_c_ret",    1, 1,12, 0, 0, 0, 0, 0, 1, 1,10, 0, 0, 0,  1, 0, 0, (B<<10)|(B<<11),  2, 0, 0));
        tbl.push_back(v("cap_c_acc",    1, 1,12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, B<<11,            1, 0, 0));
        tbl.push_back(v("ret_r11",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1,11, 0, 0, 0,  0, 0, 0, (B<<11)|(B<<12),  2, 0, 0));
        tbl.push_back(v("ret_r12",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1,12, 0, 0, 0,  0, 0, 0, B<<12,            1, 0, 0));
        tbl.push_back(v("beq_acc",      1, 0, 0, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("wait_stall",   1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,                1, 0, 1));
        tbl.push_back(v("resolve_nt",   1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0,  1, 0, 0, 0,                1, 0, 1));
        tbl.push_back(v("nt_accept",    1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("ret_r5",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0,  0, 0, 0, B<<5,             1, 0, 0));
        tbl.push_back(v("acc_r8",       1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("ret_r9_zero",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0,  0, 0, 0, B<<8,             1, 0, 0));
        tbl.push_back(v("err_set",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, B<<8,             0, 1, 0));
        tbl.push_back(v("resolve_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, B<<8,             0, 1, 0));
        tbl.push_back(v("err_sticky",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, B<<8,             0, 1, 0));
        tbl.push_back(v("rst2",         1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 1,  1, 0, 0, 0,                0, 1, 0));
        tbl.push_back(v("post_rst",     1, 1, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("ret_r1",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 0, B<<1,             1, 0, 0));
        tbl.push_back(v("waw_1",        1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,                0, 0, 0));
        tbl.push_back(v("waw_2",        1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, B<<6,             1, 0, 0));
        tbl.push_back(v("waw_ret_a",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, B<<6,             2, 0, 0));
        tbl.push_back(v("waw_3",        1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, B<<6,             1, 0, 0));
        tbl.push_back(v("waw_ret_b",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, B<<6,             2, 0, 0));
        tbl.push_back(v("waw_overflow", 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, B<<6,             1, 0, 0));
        tbl.push_back(v("waw_no_wb",    1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, B<<6,             1, 0, 0));

        clr_in();
        RESET = 1;
        repeat (2) @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #3;
            chk({tbl[i].name, "/stall"},    32'(STALL),        32'(tbl[i].e_stall));
            chk({tbl[i].name, "/accept"},   32'(ISSUE_ACCEPT), 32'(tbl[i].e_acc));
            chk({tbl[i].name, "/flush"},    32'(FLUSH),        32'(tbl[i].e_flush));
            chk({tbl[i].name, "/busy"},     BUSY_VEC,          tbl[i].e_busy);
            chk({tbl[i].name, "/inflight"}, 32'(INFLIGHT),     32'(tbl[i].e_infl));
            chk({tbl[i].name, "/err"},      32'(ERR),          32'(tbl[i].e_err));
            chk({tbl[i].name, "/state"},    32'(CTRL_STATE),   32'(tbl[i].e_state));
            step();
        end

        // Taken branch: resolve two cycles after the accept, one FLUSH pulse.
        clr_in(); RESET = 1; step(); RESET = 0;
        ISSUE_VALID = 1; ISSUE_CTRL = 1;
        #3; chk("tk_beq_accept", 32'(ISSUE_ACCEPT), 1);
        step();
        clr_in(); ISSUE_VALID = 1; ISSUE_WB = 1; ISSUE_RD = 5;
        for (int k = 0; k < 2; k++) begin
            #3;
            chk("tk_wait_stall", 32'(STALL), 1);
            chk("tk_wait_noflush", 32'(FLUSH), 0);
            step();
        end
        RESOLVE = 1; RESOLVE_TAKEN = 1; RETIRE_VALID = 1;
        #3; chk("tk_resolve_stall", 32'(STALL), 1);
        chk("tk_resolve_noflush", 32'(FLUSH), 0);
        step();
        RESOLVE = 0; RESOLVE_TAKEN = 0; RETIRE_VALID = 0;
        #3; chk("tk_flush_high", 32'(FLUSH), 1);
        chk("tk_flush_stall", 32'(STALL), 1);
        chk("tk_flush_state", 32'(CTRL_STATE), 2);
        step();
        #3; chk("tk_flush_done", 32'(FLUSH), 0);
        chk("tk_resume_accept", 32'(ISSUE_ACCEPT), 1);
        chk("tk_resume_state", 32'(CTRL_STATE), 0);
        chk("tk_err_clean", 32'(ERR), 0);
        step();

        // Reset in the middle of WAIT_RES with r2 pending and ERR set.
        clr_in(); RESET = 1; step(); RESET = 0;
        RETIRE_VALID = 1;
        step();
        clr_in(); ISSUE_VALID = 1; ISSUE_WB = 1; ISSUE_RD = 2;
        #3; chk("mr_addi_accept", 32'(ISSUE_ACCEPT), 1);
        chk("mr_err_set", 32'(ERR), 1);
        step();
        clr_in(); ISSUE_VALID = 1; ISSUE_CTRL = 1;
        #3; chk("mr_beq_accept", 32'(ISSUE_ACCEPT), 1);
        step();
        clr_in(); ISSUE_VALID = 1; ISSUE_WB = 1; ISSUE_RD = 3; SRC1_REG = 2; SRC1_USED = 1;
        #3; chk("mr_wait_stall", 32'(STALL), 1);
        chk("mr_wait_state", 32'(CTRL_STATE), 1);
        chk("mr_busy_r2", BUSY_VEC, B<<2);
        chk("mr_inflight2", 32'(INFLIGHT), 2);
        step();
        RESET = 1;
        #3; chk("mr_rst_stall", 32'(STALL), 1);
        chk("mr_rst_accept", 32'(ISSUE_ACCEPT), 0);
        chk("mr_rst_busy", BUSY_VEC, 0);
        step();
        RESET = 0;
        #3; chk("mr_post_state", 32'(CTRL_STATE), 0);
        chk("mr_post_busy", BUSY_VEC, 0);
        chk("mr_post_inflight", 32'(INFLIGHT), 0);
        chk("mr_post_err", 32'(ERR), 0);
        chk("mr_post_accept", 32'(ISSUE_ACCEPT), 1);
        step();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
